// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Streams a little-endian byte image into instruction memory while
//            holding the core in reset, then releases it to fetch from word 0.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest load that fits without revisiting an address.
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] waddr_q,      waddr_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
    logic [1:0]            byte_idx_q,   byte_idx_d;
    logic [31:0]           wbuf_q,       wbuf_d;
    logic                  core_rst_q,   core_rst_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            wbuf_q       <= '0;
            core_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            wbuf_q       <= wbuf_d;
            core_rst_q   <= core_rst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        wbuf_d       = wbuf_q;
        core_rst_d   = core_rst_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    waddr_d      = '0;
                    byte_idx_d   = '0;
                    words_left_d = (num_words > CAPACITY) ? CAPACITY : num_words;
                    if (num_words == '0) begin
                        state_d    = DONE;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d    = RECV;
                        core_rst_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (byte_valid) begin
                    wbuf_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                waddr_d      = waddr_q + ADDR_WIDTH'(1);
                words_left_d = words_left_q - (ADDR_WIDTH + 1)'(1);
                if (words_left_q == (ADDR_WIDTH + 1)'(1)) begin
                    state_d    = DONE;
                    core_rst_d = 1'b0;
                end else begin
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_ready = (state_q == RECV);
    assign imem_we    = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign imem_waddr = waddr_q;
    assign imem_wdata = wbuf_q;
    assign core_rst   = core_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader (ADDR_WIDTH 8 and 2 instances)
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sel, byte_valid;
    logic [8:0] nw;
    logic [7:0] byte_data;
    logic       start1, start2;

    assign start1 = start & ~sel;
    assign start2 = start & sel;

    logic        ready1, we1, crst1, busy1, done1;
    logic [7:0]  waddr1;
    logic [31:0] wdata1;
    logic        ready2, we2, crst2, busy2, done2;
    logic [1:0]  waddr2;
    logic [31:0] wdata2;

    imem_loader #(.ADDR_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .num_words(nw),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready1),
        .imem_we(we1), .imem_waddr(waddr1), .imem_wdata(wdata1),
        .core_rst(crst1), .busy(busy1), .done(done1)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_dut_small (
        .clk(clk), .rst(rst), .start(start2), .num_words(nw[2:0]),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready2),
        .imem_we(we2), .imem_waddr(waddr2), .imem_wdata(wdata2),
        .core_rst(crst2), .busy(busy2), .done(done2)
    );

    logic        m_ready, m_we, m_crst, m_busy, m_done;
    logic [7:0]  m_waddr;
    logic [31:0] m_wdata;
    assign m_ready = sel ? ready2 : ready1;
    assign m_we    = sel ? we2    : we1;
    assign m_crst  = sel ? crst2  : crst1;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_done  = sel ? done2  : done1;
    assign m_waddr = sel ? {6'b0, waddr2} : waddr1;
    assign m_wdata = sel ? wdata2 : wdata1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    wr_t        wq[$];
    logic [7:0] prog[$];

    always @(negedge clk) begin
        if (m_we) wq.push_back('{int'(m_waddr), m_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready1), 0);
        check({tag, "_we"},    32'(we1),    0);
        check({tag, "_waddr"}, 32'(waddr1), 0);
        check({tag, "_wdata"}, wdata1,      0);
        check({tag, "_crst"},  32'(crst1),  1);
        check({tag, "_busy"},  32'(busy1),  0);
        check({tag, "_done"},  32'(done1),  0);
        check({tag, "_small"}, {29'b0, crst2, busy2, ready2}, 32'b100);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; nw = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    // Drives one load and checks it against the rules: words are little-endian
    // groups of four bytes at consecutive addresses, count clamped to capacity,
    // completion 5N+1 cycles after start plus one per bubble while ready.
    task automatic do_load(input int n, input int pct, input int stall_after,
                           input int stall_len, input int poke, output int lat);
        int cap, eff, bi, bub, srem, exp_lat;
        logic [31:0] w;
        cap = sel ? 4 : 256;
        eff = (n > cap) ? cap : n;
        while (prog.size() < 4 * eff) prog.push_back(8'($urandom));
        wq.delete();
        @(negedge clk);
        start = 1'b1; nw = 9'(n); byte_valid = 1'b0;
        lat = 0; bi = 0; bub = 0; srem = stall_len;
        forever begin
            @(negedge clk);
            lat++;
            if (m_done) break;
            start = (lat == poke);
            nw    = 9'($urandom);
            if (lat > 5 * eff + 400) begin
                n_cmp++; n_fail++;
                $display("FAIL load_timeout: got no done after %0d cycles, required done", lat);
                break;
            end
            check("core_rst_held", 32'(m_crst), 1);
            if (m_ready) begin
                check("ready_only_in_recv", {29'b0, m_busy, m_we, m_done}, 32'b100);
                if (bi == stall_after && srem > 0) begin
                    byte_valid = 1'b0; srem--; bub++;
                end else if (int'($urandom_range(99)) < pct || bi >= prog.size()) begin
                    byte_valid = 1'b0; bub++;
                end else begin
                    byte_valid = 1'b1; byte_data = prog[bi]; bi++;
                end
            end else begin
                byte_valid = 1'($urandom);
                byte_data  = 8'($urandom);
            end
        end
        start = 1'b0;
        exp_lat = (eff == 0) ? 1 : 5 * eff + 1 + bub;
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("core_rst_at_done", 32'(m_crst), 0);
        check("write_count", 32'(wq.size()), 32'(eff));
        for (int i = 0; i < eff && i < wq.size(); i++) begin
            w = {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
            check("write_addr", 32'(wq[i].addr), 32'(i));
            check("write_data", wq[i].data, w);
        end
        byte_valid = 1'b1; byte_data = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_idle", {28'b0, m_ready, m_busy, m_done, m_crst}, 32'b0000);
        end
        check("post_no_write", 32'(wq.size()), 32'(eff));
        byte_valid = 1'b0;
    endtask

    typedef struct {
        int n;
        bit sel;
        int stall_after;
        int stall_len;
        int poke;
        int exp_lat;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int lat, acc, cyc;
        logic [31:0] w;

        tbl[0] = '{2, 1'b0, -1, 0, 0, 11};
        tbl[1] = '{2, 1'b0,  2, 3, 0, 14};
        tbl[2] = '{0, 1'b0, -1, 0, 0,  1};
        tbl[3] = '{7, 1'b1, -1, 0, 0, 21};
        tbl[4] = '{3, 1'b0, -1, 0, 3, 16};
        tbl[5] = '{1, 1'b1, -1, 0, 0,  6};

        sel = 1'b0;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; nw = '0;

        for (int i = 0; i < 6; i++) begin
            sel = tbl[i].sel;
            do_reset();
            prog.delete();
            if (i < 2) prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
            do_load(tbl[i].n, 0, tbl[i].stall_after, tbl[i].stall_len, tbl[i].poke, lat);
            check("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
            if (i < 2 && wq.size() == 2) begin
                check("word0_const", wq[0].data, 32'h00500013);
                check("word1_const", wq[1].data, 32'h00100093);
            end
        end

        // Reset after six accepted bytes of a two-word load.
        sel = 1'b0;
        do_reset();
        prog.delete();
        repeat (8) prog.push_back(8'($urandom));
        wq.delete();
        @(negedge clk);
        start = 1'b1; nw = 9'd2;
        acc = 0; cyc = 0;
        while (acc < 6 && cyc < 100) begin
            @(negedge clk);
            start = 1'b0; cyc++;
            if (m_ready) begin
                byte_valid = 1'b1; byte_data = prog[acc]; acc++;
            end else begin
                byte_valid = 1'b0;
            end
        end
        check("rst_mid_reached", 32'(acc), 6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        byte_valid = 1'b0;
        @(negedge clk);
        w = {prog[3], prog[2], prog[1], prog[0]};
        check("rst_mid_writes", 32'(wq.size()), 1);
        if (wq.size() > 0) begin
            check("rst_mid_addr", 32'(wq[0].addr), 0);
            check("rst_mid_data", wq[0].data, w);
        end
        @(negedge clk);
        rst = 1'b0;
        prog.delete();
        do_load(1, 0, -1, 0, 0, lat);

        // Back-to-back randomized loads without intervening reset.
        for (int r = 0; r < 25; r++) begin
            int n, poke;
            sel  = 1'($urandom_range(1));
            n    = sel ? int'($urandom_range(7)) : int'($urandom_range(5));
            poke = ($urandom_range(1) == 1) ? int'($urandom_range(6, 2)) : 0;
            prog.delete();
            do_load(n, 30, -1, 0, poke, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
